// File: rtl/pow_pkg.sv
// Shared constants for the proof-of-work target checker: controller states,
// verdict encoding and default geometry.
package pow_pkg;

  localparam int unsigned NBYTES_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CMP  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // One-hot verdict, bit order {above, equal, below}; all-zero means no verdict.
  typedef logic [2:0] verdict_t;

  localparam verdict_t VERDICT_NONE  = 3'b000;
  localparam verdict_t VERDICT_BELOW = 3'b001;
  localparam verdict_t VERDICT_EQUAL = 3'b010;
  localparam verdict_t VERDICT_ABOVE = 3'b100;

endpackage

// File: rtl/pow_target_checker_if.sv
// Hash/target input handshake and verdict output handshake of the target checker.
interface pow_target_checker_if
  import pow_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEF
) ();

  localparam int unsigned BYTES_W = $clog2(NBYTES + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   hash;
  logic [8*NBYTES-1:0]   target;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_below;
  logic                  out_equal;
  logic                  out_above;
  logic [BYTES_W-1:0]    out_bytes;

  // Producer of pairs and consumer of verdicts.
  modport master (
    output in_valid, hash, target, out_ready,
    input  in_ready, out_valid, out_below, out_equal, out_above, out_bytes
  );

  // The checker itself.
  modport slave (
    input  in_valid, hash, target, out_ready,
    output in_ready, out_valid, out_below, out_equal, out_above, out_bytes
  );

endinterface

// File: rtl/byte_cmp8.sv
// Combinational 8-bit magnitude comparator; exactly one of lt/eq/gt is high.
module byte_cmp8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);

  // Equality from XNOR of every bit pair, not from a bitwise AND of operands.
  assign eq = &(a ~^ b);
  assign lt = (a < b);
  assign gt = ~eq & ~lt;

endmodule

// File: rtl/pow_target_checker.sv
// Serial MSB-first hash vs. target comparison through one shared byte comparator,
// with a one-verdict-per-pair handshake and saturating check/hit statistics.
module pow_target_checker
  import pow_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pow_target_checker_if.slave  bus,
  output logic                 busy,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     stat_checks,
  output logic [CNT_W-1:0]     stat_hits
);

  localparam int unsigned IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned BYTES_W = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NBYTES - 1);
  localparam logic [BYTES_W-1:0] BYTES_ALL = BYTES_W'(NBYTES);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [8*NBYTES-1:0]  hash_q, hash_d;
  logic [8*NBYTES-1:0]  target_q, target_d;
  verdict_t             verdict_q, verdict_d;
  logic [BYTES_W-1:0]   bytes_q, bytes_d;
  logic [CNT_W-1:0]     checks_q, checks_d;
  logic [CNT_W-1:0]     hits_q, hits_d;

  logic [7:0] hash_byte;
  logic [7:0] target_byte;
  logic       cmp_lt;
  logic       cmp_eq;
  logic       cmp_gt;
  logic       out_hs;

  assign hash_byte   = hash_q[{idx_q, 3'b000} +: 8];
  assign target_byte = target_q[{idx_q, 3'b000} +: 8];

  byte_cmp8 u_cmp (
    .a  (hash_byte),
    .b  (target_byte),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  assign out_hs = (state_q == ST_DONE) && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hash_d    = hash_q;
    target_d  = target_q;
    verdict_d = verdict_q;
    bytes_d   = bytes_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          hash_d   = bus.hash;
          target_d = bus.target;
          idx_d    = IDX_LAST;
          state_d  = ST_CMP;
        end
      end
      ST_CMP: begin
        if (cmp_lt || cmp_gt) begin
          verdict_d = cmp_gt ? VERDICT_ABOVE : VERDICT_BELOW;
          bytes_d   = BYTES_ALL - BYTES_W'(idx_q);
          state_d   = ST_DONE;
        end else if (idx_q == '0) begin
          verdict_d = VERDICT_EQUAL;
          bytes_d   = BYTES_ALL;
          state_d   = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        // The verdict registers are left untouched; they only mean something in DONE.
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear beats a coincident handshake; both counters stick at all-ones.
  always_comb begin
    checks_d = checks_q;
    hits_d   = hits_q;
    if (stat_clr) begin
      checks_d = '0;
      hits_d   = '0;
    end else if (out_hs) begin
      if (checks_q != '1) begin
        checks_d = checks_q + 1'b1;
      end
      if ((verdict_q == VERDICT_BELOW) && (hits_q != '1)) begin
        hits_d = hits_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= IDX_LAST;
      hash_q    <= '0;
      target_q  <= '0;
      verdict_q <= VERDICT_NONE;
      bytes_q   <= '0;
      checks_q  <= '0;
      hits_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hash_q    <= hash_d;
      target_q  <= target_d;
      verdict_q <= verdict_d;
      bytes_q   <= bytes_d;
      checks_q  <= checks_d;
      hits_q    <= hits_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_below = verdict_q[0];
  assign bus.out_equal = verdict_q[1];
  assign bus.out_above = verdict_q[2];
  assign bus.out_bytes = bytes_q;
  assign busy          = (state_q != ST_IDLE);
  assign stat_checks   = checks_q;
  assign stat_hits     = hits_q;

endmodule

// File: tb/tb_pow_target_checker.sv
// Directed and randomized checks of pow_target_checker against a whole-number
// comparison model.
module tb_pow_target_checker;
  import pow_pkg::*;

  localparam int unsigned NB = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned SAT = (1 << CW) - 1;

  typedef logic [8*NB-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stat_clr = 1'b0;
  logic          busy;
  logic [CW-1:0] stat_checks;
  logic [CW-1:0] stat_hits;

  pow_target_checker_if #(.NBYTES(NB)) bus ();

  pow_target_checker #(
    .NBYTES (NB),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .stat_clr    (stat_clr),
    .stat_checks (stat_checks),
    .stat_hits   (stat_hits)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_checks = 0;
  int m_hits = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < NB / 4; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Reference: compare as plain unsigned numbers; bytes examined is the position
  // of the most significant differing byte counted from the top.
  function automatic void model(input vec_t h, input vec_t t, output logic [2:0] flags,
                                output int nbytes);
    vec_t d;
    int   top;
    if (h < t) flags = 3'b001;
    else if (h == t) flags = 3'b010;
    else flags = 3'b100;
    if (h == t) begin
      nbytes = NB;
    end else begin
      d = h ^ t;
      top = 0;
      for (int b = 0; b < 8 * NB; b++) if (d[b]) top = b;
      nbytes = NB - top / 8;
    end
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ":in_ready"}, bus.in_ready, 1);
    check({tag, ":out_valid"}, bus.out_valid, 0);
    check({tag, ":flags"}, {bus.out_above, bus.out_equal, bus.out_below}, 0);
    check({tag, ":out_bytes"}, bus.out_bytes, 0);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":stat_checks"}, stat_checks, 0);
    check({tag, ":stat_hits"}, stat_hits, 0);
  endtask

  task automatic run_pair(input vec_t h, input vec_t t, input int stall, input logic clr_hs,
                          input string tag);
    logic [2:0] ef;
    int         eb;
    int         cyc;
    model(h, t, ef, eb);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.hash     = h;
    bus.target   = t;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the DUT must work from its own copy.
    bus.in_valid = 1'b0;
    bus.hash     = rand_vec();
    bus.target   = rand_vec();
    check({tag, ":busy"}, busy, 1);
    check({tag, ":in_ready_busy"}, bus.in_ready, 0);
    cyc = 0;
    while (!bus.out_valid && cyc < NB + 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":latency"}, cyc, eb);
    check({tag, ":flags"}, {bus.out_above, bus.out_equal, bus.out_below}, ef);
    check({tag, ":out_bytes"}, bus.out_bytes, eb);
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, ":stall_valid"}, bus.out_valid, 1);
      check({tag, ":stall_flags"}, {bus.out_above, bus.out_equal, bus.out_below}, ef);
      check({tag, ":stall_bytes"}, bus.out_bytes, eb);
      check({tag, ":stall_in_ready"}, bus.in_ready, 0);
      check({tag, ":stall_checks"}, stat_checks, m_checks);
      check({tag, ":stall_hits"}, stat_hits, m_hits);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    stat_clr      = clr_hs;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    stat_clr      = 1'b0;
    if (clr_hs) begin
      m_checks = 0;
      m_hits   = 0;
    end else begin
      m_checks = sat_inc(m_checks);
      if (ef == 3'b001) m_hits = sat_inc(m_hits);
    end
    check({tag, ":post_valid"}, bus.out_valid, 0);
    check({tag, ":post_in_ready"}, bus.in_ready, 1);
    check({tag, ":post_busy"}, busy, 0);
    check({tag, ":stat_checks"}, stat_checks, m_checks);
    check({tag, ":stat_hits"}, stat_hits, m_hits);
  endtask

  function automatic void make_below(output vec_t h, output vec_t t);
    int tb;
    t = rand_vec();
    h = rand_vec();
    tb = $urandom_range(1, 255);
    t[8*NB-1 -: 8] = 8'(tb);
    h[8*NB-1 -: 8] = 8'($urandom_range(0, tb - 1));
  endfunction

  initial begin
    vec_t h;
    vec_t t;
    int   pos;
    int   seen;

    bus.in_valid  = 1'b0;
    bus.hash      = '0;
    bus.target    = '0;
    bus.out_ready = 1'b0;

    #12;
    check_reset_outputs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_released");

    // Most significant byte decides on the first cycle.
    h = '0;
    h[8*NB-1 -: 8] = 8'h10;
    t = rand_vec();
    t[8*NB-1 -: 8] = 8'h20;
    run_pair(h, t, 0, 1'b0, "msb_below");
    check("msb_hits", stat_hits, 1);

    // Only byte 0 differs: every byte is examined.
    t = rand_vec();
    h = t;
    h[7:0] = 8'h05;
    t[7:0] = 8'h04;
    run_pair(h, t, 0, 1'b0, "deep_above");

    h = {NB{8'hA5}};
    run_pair(h, h, 0, 1'b0, "full_equal");

    make_below(h, t);
    run_pair(h, t, 10, 1'b0, "backpressure");

    for (int i = 0; i < 24; i++) begin
      t = rand_vec();
      case ($urandom_range(0, 3))
        0: h = rand_vec();
        1: h = t;
        2: begin
          h = t;
          pos = $urandom_range(0, NB - 1);
          h[8*pos +: 8] = h[8*pos +: 8] ^ 8'($urandom_range(1, 255));
        end
        default: begin
          h = t;
          pos = ($urandom_range(0, 1) == 0) ? 0 : NB - 1;
          h[8*pos +: 8] = h[8*pos +: 8] ^ 8'($urandom_range(1, 255));
        end
      endcase
      run_pair(h, t, $urandom_range(0, 2), 1'b0, "random");
    end

    // Asynchronous reset in the middle of a full-length comparison.
    t = rand_vec();
    h = t;
    h[7:0] = t[7:0] ^ 8'h01;
    bus.in_valid = 1'b1;
    bus.hash     = h;
    bus.target   = t;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_checks = 0;
    m_hits   = 0;
    check_reset_outputs("reset_mid_cmp");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < NB + 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("reset_no_verdict", seen, 0);
    make_below(h, t);
    run_pair(h, t, 1, 1'b0, "after_reset");

    // Saturation of both counters, then clear colliding with a handshake.
    make_below(h, t);
    run_pair(h, t, 0, 1'b1, "clear_hs_a");
    for (int i = 0; i < 17; i++) begin
      make_below(h, t);
      run_pair(h, t, 0, 1'b0, "saturate");
    end
    check("sat_checks", stat_checks, SAT);
    check("sat_hits", stat_hits, SAT);
    t = rand_vec();
    run_pair(t, t, 0, 1'b1, "clear_hs_b");
    check("clear_checks", stat_checks, 0);
    check("clear_hits", stat_hits, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
